// File: rtl/crc8_framer.sv
// crc8_framer: forwards payload bytes through a single registered output slot
// while accumulating a CRC-8 (poly 0x07, MSB-first, no reflection), then
// appends the final CRC byte flagged with m_last.
module crc8_framer #(
    parameter logic [7:0] INIT    = 8'h00,
    parameter logic [7:0] XOR_OUT = 8'h00,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic {
        ST_PAYLOAD = 1'b0,
        ST_APPEND  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       crc, crc_nxt;
    logic [7:0]       m_data_nxt;
    logic             m_valid_nxt, m_last_nxt;
    logic [CNT_W-1:0] frame_count_nxt;
    logic             slot_free;
    logic             accept;

    // One full byte of CRC-8 update, bit 7 of the data first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // The slot can be reloaded when it is empty or being drained this cycle.
    assign slot_free = !m_valid || m_ready;
    assign s_ready   = (state == ST_PAYLOAD) && slot_free;
    assign accept    = s_valid && s_ready;

    // Next-state and next-slot logic; a stalled slot simply holds.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt       = state;
        crc_nxt         = crc;
        m_data_nxt      = m_data;
        m_valid_nxt     = m_valid;
        m_last_nxt      = m_last;
        frame_count_nxt = frame_count;

        case (state)
            ST_PAYLOAD: begin
                if (accept) begin
                    m_data_nxt  = s_data;
                    m_last_nxt  = 1'b0;
                    m_valid_nxt = 1'b1;
                    crc_nxt     = crc8_step(crc, s_data);
                    if (s_last) begin
                        state_nxt = ST_APPEND;
                    end
                end else if (slot_free) begin
                    m_valid_nxt = 1'b0;
                end
            end
            ST_APPEND: begin
                if (slot_free) begin
                    m_data_nxt      = crc ^ XOR_OUT;
                    m_last_nxt      = 1'b1;
                    m_valid_nxt     = 1'b1;
                    crc_nxt         = INIT;
                    frame_count_nxt = frame_count + CNT_W'(1);
                    state_nxt       = ST_PAYLOAD;
                end
            end
            default: begin
                state_nxt = ST_PAYLOAD;
            end
        endcase
    end

    // State, CRC accumulator, output slot and frame counter registers.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            state       <= ST_PAYLOAD;
            crc         <= INIT;
            m_data      <= 8'h00;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            crc         <= crc_nxt;
            m_data      <= m_data_nxt;
            m_valid     <= m_valid_nxt;
            m_last      <= m_last_nxt;
            frame_count <= frame_count_nxt;
        end
    end

endmodule

// File: tb/tb_crc8_framer.sv
// Testbench for crc8_framer: three instances (default parameters,
// INIT=FF/XOR_OUT=55, CNT_W=2) receive identical stimulus.
module tb_crc8_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        m_ready;

    logic        s_ready0, s_ready1, s_ready2;
    logic [7:0]  m_data0, m_data1, m_data2;
    logic        m_valid0, m_valid1, m_valid2;
    logic        m_last0, m_last1, m_last2;
    logic [15:0] fc0, fc1;
    logic [1:0]  fc2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] stim_data [0:31];
    logic       stim_last [0:31];
    int         stim_n;
    logic [7:0] out_data  [0:63];
    logic       out_last  [0:63];
    int         out_n;
    logic [7:0] crc1_q    [0:7];
    int         crc1_n;
    logic [1:0] fc2_q     [0:7];
    int         fc2_n;
    int         ready_low;
    logic [15:0] lfsr = 16'hACE1;

    always #5 clk = ~clk;

    crc8_framer u_dut0 (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready0),
        .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready),
        .frame_count(fc0)
    );

    crc8_framer #(.INIT(8'hFF), .XOR_OUT(8'h55)) u_dut1 (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready1),
        .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1), .m_ready(m_ready),
        .frame_count(fc1)
    );

    crc8_framer #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_last(m_last2), .m_ready(m_ready),
        .frame_count(fc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Place "123456789" at stim[base..base+8], last flag on 0x39.
    task automatic load_check_frame(input int base);
        for (int i = 0; i < 9; i++) begin
            stim_data[base + i] = 8'h31 + 8'(i);
            stim_last[base + i] = (i == 8);
        end
    endtask

    // Drive stim[0..stim_n-1] and collect everything emitted by dut0 until
    // every frame's CRC byte has left the slot. Called at posedge + 1.
    task automatic run_stream(input bit bp, input int budget);
        int   idx = 0;
        int   ends = 0;
        int   exp_ends = 0;
        int   cyc = 0;
        logic prev_hold = 1'b0;
        logic [7:0] prev_d = 8'h00;
        logic prev_l = 1'b0;
        for (int i = 0; i < stim_n; i++) if (stim_last[i]) exp_ends++;
        out_n = 0; crc1_n = 0; fc2_n = 0; ready_low = 0;
        while ((idx < stim_n || ends < exp_ends) && cyc < budget) begin
            lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            m_ready = bp ? lfsr[0] : 1'b1;
            if (idx < stim_n) begin
                s_valid = 1'b1;
                s_data  = stim_data[idx];
                s_last  = stim_last[idx];
            end else begin
                // Junk on an idle bus must be ignored.
                s_valid = 1'b0;
                s_data  = 8'hEE;
                s_last  = 1'b1;
            end
            @(negedge clk);
            if (prev_hold) begin
                check("hold_data", m_data0, prev_d);
                check("hold_last", m_last0, prev_l);
                check("hold_valid", m_valid0, 1);
            end
            prev_hold = m_valid0 && !m_ready;
            prev_d    = m_data0;
            prev_l    = m_last0;
            if (!s_ready0) ready_low++;
            if (s_valid && s_ready0) idx++;
            if (m_valid0 && m_ready && out_n < 64) begin
                out_data[out_n] = m_data0;
                out_last[out_n] = m_last0;
                out_n++;
                if (m_last0) begin
                    ends++;
                    if (fc2_n < 8) begin
                        fc2_q[fc2_n] = fc2;
                        fc2_n++;
                    end
                end
            end
            if (m_valid1 && m_ready && m_last1 && crc1_n < 8) begin
                crc1_q[crc1_n] = m_data1;
                crc1_n++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stream_complete", (idx == stim_n && ends == exp_ends), 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic check_frame_out(input string tag, input int base, input logic [7:0] crc);
        for (int i = 0; i < 9; i++) begin
            check({tag, "_data"}, out_data[base + i], 8'h31 + 8'(i));
            check({tag, "_last0"}, out_last[base + i], 0);
        end
        check({tag, "_crc"}, out_data[base + 9], crc);
        check({tag, "_crclast"}, out_last[base + 9], 1);
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state; slot empty so s_ready is high even with m_ready low.
        @(negedge clk);
        check("rst_m_valid", m_valid0, 0);
        check("rst_m_data", m_data0, 8'h00);
        check("rst_m_last", m_last0, 0);
        check("rst_fc", fc0, 0);
        check("rst_s_ready", s_ready0, 1);
        @(posedge clk);
        #1;

        // Check string at full rate.
        do_reset();
        stim_n = 9;
        load_check_frame(0);
        run_stream(1'b0, 200);
        check("t1_count", out_n, 10);
        check_frame_out("t1", 0, 8'hF4);
        check("t1_ready_low", ready_low, 1);
        check("t1_fc", fc0, 1);
        check("t1_crc_p", crc1_q[0], 8'hAE);

        // Single-byte frames.
        do_reset();
        stim_n = 3;
        stim_data[0] = 8'h00; stim_last[0] = 1'b1;
        stim_data[1] = 8'h01; stim_last[1] = 1'b1;
        stim_data[2] = 8'hFF; stim_last[2] = 1'b1;
        run_stream(1'b0, 200);
        check("t2_count", out_n, 6);
        check("t2_d0", out_data[0], 8'h00);
        check("t2_c0", out_data[1], 8'h00);
        check("t2_d1", out_data[2], 8'h01);
        check("t2_c1", out_data[3], 8'h07);
        check("t2_d2", out_data[4], 8'hFF);
        check("t2_c2", out_data[5], 8'hF3);
        check("t2_lastflags", {out_last[0], out_last[1], out_last[2],
                               out_last[3], out_last[4], out_last[5]}, 6'b010101);
        check("t2_fc", fc0, 3);

        // Backpressure with a pseudo-random m_ready.
        do_reset();
        stim_n = 9;
        load_check_frame(0);
        run_stream(1'b1, 2000);
        check("t3_count", out_n, 10);
        check_frame_out("t3", 0, 8'hF4);
        check("t3_fc", fc0, 1);

        // Two back-to-back frames: CRC reinitialised between them.
        do_reset();
        stim_n = 18;
        load_check_frame(0);
        load_check_frame(9);
        run_stream(1'b0, 200);
        check("t4_count", out_n, 20);
        check_frame_out("t4a", 0, 8'hF4);
        check_frame_out("t4b", 10, 8'hF4);
        check("t4_crc_p0", crc1_q[0], 8'hAE);
        check("t4_crc_p1", crc1_q[1], 8'hAE);
        check("t4_ready_low", ready_low, 2);
        check("t4_fc", fc0, 2);

        // Reset in the middle of a frame.
        do_reset();
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_data  = 8'h31 + 8'(k);
            s_last  = 1'b0;
            @(negedge clk);
            check("t5_accept", s_ready0, 1);
            @(posedge clk);
            #1;
        end
        reset   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_m_valid", m_valid0, 0);
        check("t5_m_data", m_data0, 8'h00);
        check("t5_fc", fc0, 0);
        @(posedge clk);
        #1;
        stim_n = 9;
        load_check_frame(0);
        run_stream(1'b0, 200);
        check("t5_count", out_n, 10);
        check_frame_out("t5", 0, 8'hF4);
        check("t5_fc_after", fc0, 1);

        // Narrow counter wraps modulo 4.
        do_reset();
        stim_n = 5;
        for (int i = 0; i < 5; i++) begin
            stim_data[i] = 8'h10 + 8'(i);
            stim_last[i] = 1'b1;
        end
        run_stream(1'b0, 200);
        check("t6_frames", fc2_n, 5);
        check("t6_fc0", fc2_q[0], 1);
        check("t6_fc1", fc2_q[1], 2);
        check("t6_fc2", fc2_q[2], 3);
        check("t6_fc3", fc2_q[3], 0);
        check("t6_fc4", fc2_q[4], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
